serv_rf_ram_arb: RTL and testbench

SERV_RF_RAM_ARB -- requirements
Module: serv_rf_ram_arb

---
 rtl/serv_rf_ram_arb_if.sv | 53 +++++
 rtl/serv_rf_ram_arb.sv | 163 ++++++++++++++++
 tb/tb_serv_rf_ram_arb.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serv_rf_ram_arb_if.sv
// Bus bundle between the SERV core, a host port and the RF RAM.
// Ports: core req/addr/data/enables, host valid/ready word port, RAM side.
interface serv_rf_ram_arb_if #(
    parameter int width = 8,
    parameter int aw    = 8
);
    logic             i_core_rreq;
    logic             i_core_wreq;
    logic             o_core_rreq;
    logic             o_core_wreq;
    logic [aw-1:0]    i_core_waddr;
    logic [aw-1:0]    i_core_raddr;
    logic [width-1:0] i_core_wdata;
    logic             i_core_wen;
    logic             i_core_ren;
    logic             i_host_valid;
    logic             i_host_we;
    logic [aw-1:0]    i_host_addr;
    logic [width-1:0] i_host_wdata;
    logic             o_host_ready;
    logic [width-1:0] o_host_rdata;
    logic [aw-1:0]    o_waddr;
    logic [aw-1:0]    o_raddr;
    logic [width-1:0] o_wdata;
    logic             o_wen;
    logic             o_ren;
    logic [width-1:0] i_rdata;
    logic             o_init_done;

    modport slave (
        input  i_core_rreq, i_core_wreq,
        input  i_core_waddr, i_core_raddr, i_core_wdata,
        input  i_core_wen, i_core_ren,
        input  i_host_valid, i_host_we, i_host_addr, i_host_wdata,
        input  i_rdata,
        output o_core_rreq, o_core_wreq,
        output o_host_ready, o_host_rdata,
        output o_waddr, o_raddr, o_wdata, o_wen, o_ren,
        output o_init_done
    );

    modport master (
        output i_core_rreq, i_core_wreq,
        output i_core_waddr, i_core_raddr, i_core_wdata,
        output i_core_wen, i_core_ren,
        output i_host_valid, i_host_we, i_host_addr, i_host_wdata,
        output i_rdata,
        input  o_core_rreq, o_core_wreq,
        input  o_host_ready, o_host_rdata,
        input  o_waddr, o_raddr, o_wdata, o_wen, o_ren,
        input  o_init_done
    );
endinterface

// File: rtl/serv_rf_ram_arb.sv
// RF RAM arbiter: clears the RAM after reset, then shares it between the
// SERV core (priority, owns the RAM for 'hold' cycles per request) and a
// host word port. Ports: i_clk, i_rst_n (async, active-low), bus (slave).
module serv_rf_ram_arb #(
    parameter int width = 8,
    parameter int aw    = 8,
    parameter int hold  = 40
) (
    input logic                i_clk,
    input logic                i_rst_n,
    serv_rf_ram_arb_if.slave   bus
);
    localparam int CW = $clog2(hold + 1);
    localparam logic [CW-1:0] HOLD_M1 = CW'(hold - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_CORE,
        S_HOST_WR,
        S_HOST_RD,
        S_HOST_RDATA
    } state_t;

    state_t           r_state;
    logic [aw-1:0]    r_clr;
    logic [CW-1:0]    r_cnt;
    logic             r_rpend;
    logic             r_wpend;
    logic             r_init_done;
    logic             r_host_ready;
    logic [width-1:0] r_host_rdata;
    logic [aw-1:0]    r_haddr;
    logic [width-1:0] r_hwdata;

    logic             w_core_st;
    logic             w_rreq;
    logic             w_wreq;
    logic             w_fwd;

    // Core owns the RAM in IDLE and CORE; pending flags only ever hold
    // requests that arrived while it did not.
    assign w_core_st = (r_state == S_IDLE) || (r_state == S_CORE);
    assign w_rreq    = w_core_st & (r_rpend | bus.i_core_rreq);
    assign w_wreq    = w_core_st & (r_wpend | bus.i_core_wreq);
    assign w_fwd     = w_rreq | w_wreq;

    assign bus.o_core_rreq  = w_rreq;
    assign bus.o_core_wreq  = w_wreq;
    assign bus.o_host_ready = r_host_ready;
    assign bus.o_host_rdata = r_host_rdata;
    assign bus.o_init_done  = r_init_done;

    always_comb begin
        bus.o_wen   = 1'b0;
        bus.o_ren   = 1'b0;
        bus.o_waddr = r_haddr;
        bus.o_raddr = r_haddr;
        bus.o_wdata = r_hwdata;
        unique case (r_state)
            S_INIT: begin
                // Gate with reset so nothing is written while held.
                bus.o_wen   = i_rst_n;
                bus.o_waddr = r_clr;
                bus.o_wdata = '0;
            end
            S_IDLE, S_CORE: begin
                bus.o_wen   = bus.i_core_wen;
                bus.o_ren   = bus.i_core_ren;
                bus.o_waddr = bus.i_core_waddr;
                bus.o_raddr = bus.i_core_raddr;
                bus.o_wdata = bus.i_core_wdata;
            end
            S_HOST_WR: begin
                bus.o_wen = 1'b1;
            end
            S_HOST_RD: begin
                bus.o_ren = 1'b1;
            end
            S_HOST_RDATA: begin
                bus.o_wen = 1'b0;
            end
            default: begin
                bus.o_wen = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_INIT;
            r_clr        <= '0;
            r_cnt        <= '0;
            r_rpend      <= 1'b0;
            r_wpend      <= 1'b0;
            r_init_done  <= 1'b0;
            r_host_ready <= 1'b0;
            r_host_rdata <= '0;
            r_haddr      <= '0;
            r_hwdata     <= '0;
        end else begin
            r_host_ready <= 1'b0;

            if (w_core_st) begin
                r_rpend <= 1'b0;
                r_wpend <= 1'b0;
            end else begin
                if (bus.i_core_rreq) r_rpend <= 1'b1;
                if (bus.i_core_wreq) r_wpend <= 1'b1;
            end

            unique case (r_state)
                S_INIT: begin
                    r_clr <= r_clr + 1'b1;
                    if (&r_clr) begin
                        r_state     <= S_IDLE;
                        r_init_done <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (w_fwd) begin
                        r_state <= S_CORE;
                        r_cnt   <= HOLD_M1;
                    end else if (bus.i_host_valid && !r_host_ready) begin
                        // Ready still high means the previous access is
                        // just finishing; do not restart on the stale valid.
                        r_haddr  <= bus.i_host_addr;
                        r_hwdata <= bus.i_host_wdata;
                        if (bus.i_host_we) begin
                            r_state      <= S_HOST_WR;
                            r_host_ready <= 1'b1;
                        end else begin
                            r_state <= S_HOST_RD;
                        end
                    end
                end
                S_CORE: begin
                    if (w_fwd) begin
                        r_cnt <= HOLD_M1;
                    end else if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_HOST_WR: begin
                    r_state <= S_IDLE;
                end
                S_HOST_RD: begin
                    r_state <= S_HOST_RDATA;
                end
                S_HOST_RDATA: begin
                    r_host_rdata <= bus.i_rdata;
                    r_host_ready <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serv_rf_ram_arb.sv
// Self-checking bench for serv_rf_ram_arb with a registered RAM model.
// Ports: none; drives the arbiter through serv_rf_ram_arb_if.
module tb_serv_rf_ram_arb;
    localparam int W    = 8;
    localparam int AW   = 8;
    localparam int HOLD = 40;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serv_rf_ram_arb_if #(.width(W), .aw(AW)) bus ();

    serv_rf_ram_arb #(.width(W), .aw(AW), .hold(HOLD)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    // RAM model, pre-filled with garbage so the clear is observable.
    logic [W-1:0] mem [256] = '{default: 8'hEE};
    always @(posedge clk) begin
        if (bus.o_wen) mem[bus.o_waddr] <= bus.o_wdata;
        if (bus.o_ren) bus.i_rdata <= mem[bus.o_raddr];
    end

    typedef struct {
        logic       rreq, wreq, wen, ren;
        logic [7:0] waddr, raddr, wdata;
        logic       e_rreq, e_wreq, e_wen, e_ren;
        logic [7:0] e_waddr, e_wdata, e_raddr;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        bus.i_core_rreq = 1'b0;
        bus.i_core_wreq = 1'b0;
        bus.i_core_wen  = 1'b0;
        bus.i_core_ren  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Called just after a negedge with reset released; returns at the
    // negedge of the first post-clear cycle.
    task automatic init_run(input bit inj);
        int good;
        good = 0;
        for (int i = 0; i < 256; i++) begin
            bus.i_core_rreq = inj && (i == 10);
            #1;
            if (bus.o_wen && !bus.o_ren && bus.o_waddr == i[7:0] &&
                bus.o_wdata == 8'h00 && !bus.o_init_done &&
                !bus.o_core_rreq && !bus.o_host_ready)
                good++;
            @(negedge clk);
        end
        bus.i_core_rreq = 1'b0;
        chk("init_seq", 64'(good), 64'd256);
    endtask

    task automatic host_read(input logic [7:0] a, input logic [7:0] e,
                             input string name);
        @(negedge clk);
        bus.i_host_valid = 1'b1;
        bus.i_host_we    = 1'b0;
        bus.i_host_addr  = a;
        @(negedge clk);
        #1 chk({name, "_rd"},
               {bus.o_ren, bus.o_wen, bus.o_raddr, bus.o_host_ready},
               {1'b1, 1'b0, a, 1'b0});
        @(negedge clk);
        #1 chk({name, "_wait"}, {bus.o_ren, bus.o_host_ready}, 2'b00);
        @(negedge clk);
        #1 chk({name, "_rdy"}, {bus.o_host_ready, bus.o_host_rdata},
               {1'b1, e});
        @(negedge clk);
        bus.i_host_valid = 1'b0;
        #1 chk({name, "_after"},
               {bus.o_host_ready, bus.o_ren, bus.o_host_rdata},
               {1'b0, 1'b0, e});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        vec_t tv [6];
        int   cnt;
        int   bad;
        int   rdy_at;
        logic seen;

        tv[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 8'h00, 8'h11,
                  1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 8'h11, 8'h00};
        tv[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h07, 8'h00,
                  1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h07};
        tv[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00,
                  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        tv[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h80, 8'h00, 8'hFF,
                  1'b0, 1'b1, 1'b1, 1'b0, 8'h80, 8'hFF, 8'h00};
        tv[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hFE, 8'h01, 8'h5A,
                  1'b1, 1'b1, 1'b1, 1'b1, 8'hFE, 8'h5A, 8'h01};
        tv[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hC3, 8'h00,
                  1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'hC3};

        bus.i_core_rreq  = 1'b0;
        bus.i_core_wreq  = 1'b0;
        bus.i_core_waddr = '0;
        bus.i_core_raddr = '0;
        bus.i_core_wdata = '0;
        bus.i_core_wen   = 1'b0;
        bus.i_core_ren   = 1'b0;
        bus.i_host_valid = 1'b0;
        bus.i_host_we    = 1'b0;
        bus.i_host_addr  = '0;
        bus.i_host_wdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1 chk("reset",
               {bus.o_init_done, bus.o_host_ready, bus.o_wen, bus.o_ren,
                bus.o_core_rreq, bus.o_core_wreq, bus.o_host_rdata},
               64'd0);

        // Clear sequence with a core read request parked in rpend
        rst_n = 1'b1;
        init_run(1'b1);
        #1 chk("init_done", {bus.o_init_done, bus.o_wen, bus.o_core_rreq},
               3'b101);
        cnt = 1;
        for (int i = 1; i < 60; i++) begin
            @(negedge clk);
            #1 if (bus.o_core_rreq) cnt++;
        end
        chk("rpend_once", 64'(cnt), 64'd1);

        // Host write, then reads of an untouched and the written address
        @(negedge clk);
        bus.i_host_valid = 1'b1;
        bus.i_host_we    = 1'b1;
        bus.i_host_addr  = 8'h21;
        bus.i_host_wdata = 8'hA5;
        #1 chk("hw_idle", {bus.o_wen, bus.o_host_ready}, 2'b00);
        @(negedge clk);
        #1 chk("hw_cycle",
               {bus.o_wen, bus.o_ren, bus.o_waddr, bus.o_wdata,
                bus.o_host_ready},
               {1'b1, 1'b0, 8'h21, 8'hA5, 1'b1});
        @(negedge clk);
        bus.i_host_valid = 1'b0;
        #1 chk("hw_done", {bus.o_wen, bus.o_host_ready, bus.o_host_rdata},
               {1'b0, 1'b0, 8'h00});
        host_read(8'h40, 8'h00, "rd40");
        host_read(8'h21, 8'hA5, "rd21");

        // Pass-through and zero-latency forwarding table
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.i_core_rreq  = tv[i].rreq;
            bus.i_core_wreq  = tv[i].wreq;
            bus.i_core_wen   = tv[i].wen;
            bus.i_core_ren   = tv[i].ren;
            bus.i_core_waddr = tv[i].waddr;
            bus.i_core_raddr = tv[i].raddr;
            bus.i_core_wdata = tv[i].wdata;
            #1 chk($sformatf("vec%0d", i),
                   {bus.o_core_rreq, bus.o_core_wreq, bus.o_wen, bus.o_ren,
                    bus.o_waddr, bus.o_wdata, bus.o_raddr},
                   {tv[i].e_rreq, tv[i].e_wreq, tv[i].e_wen, tv[i].e_ren,
                    tv[i].e_waddr, tv[i].e_wdata, tv[i].e_raddr});
        end
        idle(HOLD + 5);

        // Core and host collide in IDLE; second core request 20 later
        bus.i_core_rreq  = 1'b1;
        bus.i_core_ren   = 1'b1;
        bus.i_core_raddr = 8'h0A;
        bus.i_host_valid = 1'b1;
        bus.i_host_we    = 1'b1;
        bus.i_host_addr  = 8'h55;
        bus.i_host_wdata = 8'h3C;
        #1 chk("arb_fwd",
               {bus.o_core_rreq, bus.o_ren, bus.o_raddr, bus.o_wen},
               {1'b1, 1'b1, 8'h0A, 1'b0});
        rdy_at = -1;
        bad    = 0;
        for (int c = 1; c < 100; c++) begin
            @(negedge clk);
            bus.i_core_rreq  = 1'b0;
            bus.i_core_ren   = 1'b0;
            bus.i_core_wreq  = (c == 20);
            bus.i_core_wen   = (c == 20);
            bus.i_core_waddr = 8'h12;
            bus.i_core_wdata = 8'h77;
            #1;
            if (c == 20) begin
                chk("wreq_zero_lat",
                    {bus.o_core_wreq, bus.o_wen, bus.o_waddr, bus.o_wdata,
                     bus.o_host_ready},
                    {1'b1, 1'b1, 8'h12, 8'h77, 1'b0});
            end else if (bus.o_host_ready) begin
                rdy_at = c;
                chk("arb_host", {bus.o_wen, bus.o_waddr, bus.o_wdata},
                    {1'b1, 8'h55, 8'h3C});
                break;
            end else if (bus.o_wen || bus.o_ren || bus.o_core_rreq ||
                         bus.o_core_wreq) begin
                bad++;
            end
        end
        chk("arb_ready_cycle", 64'(rdy_at), 64'(20 + HOLD + 2));
        chk("arb_core_only", 64'(bad), 64'd0);
        @(negedge clk);
        bus.i_host_valid = 1'b0;
        idle(2);

        // Reset during a host read
        bus.i_host_valid = 1'b1;
        bus.i_host_we    = 1'b0;
        bus.i_host_addr  = 8'h21;
        @(negedge clk);
        #1 chk("rst_rd_ren", {bus.o_ren, bus.o_raddr}, {1'b1, 8'h21});
        #1 rst_n = 1'b0;
        #1 chk("rst_abort",
               {bus.o_ren, bus.o_wen, bus.o_host_ready, bus.o_host_rdata,
                bus.o_init_done},
               64'd0);
        bus.i_host_valid = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1 seen = seen | bus.o_host_ready;
        end
        chk("rst_no_ready", {63'd0, seen}, 64'd0);
        rst_n = 1'b1;
        init_run(1'b0);
        #1 chk("init_done2", {bus.o_init_done, bus.o_wen, bus.o_core_rreq},
               3'b100);
        host_read(8'h21, 8'h00, "rd21_clr");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
